motor_bridge_driver: RTL and testbench
======================================

Name: motor_bridge_driver

Overview:
Two-channel H-bridge drive stage that sits directly downstream of the PWM tick generator. It consumes a one-cycle timebase strobe plus per-channel duty/direction commands. It drives the four bridge inputs (IN1/IN2 for motor A and motor B) with glitch-free, period-aligned PWM. It also inserts a forced-off dead interval whenever a channel reverses direction.

Parameters:
PERIOD, 100, PWM period in ticks; duty is expressed in ticks (0..PERIOD).
DEAD_TICKS, 4, ticks with both bridge inputs low on a direction reversal (≥1).
DUTY_W, 8, width of the duty command (must hold PERIOD).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle timebase strobe from the PWM tick generator; all PWM timing advances only on tick
en  in  1  global drive enable; low forces coast
cmd_valid  in  1  command strobe, always accepted (no back-pressure)
cmd_ch  in  1  0 = channel A, 1 = channel B
cmd_duty  in  DUTY_W  requested duty in ticks
cmd_dir  in  1  0 = forward (drive IN1), 1 = reverse (drive IN2)
in1_a  out  1  bridge input 1, motor A
in2_a  out  1  bridge input 2, motor A
in1_b  out  1  bridge input 1, motor B
in2_b  out  1  bridge input 2, motor B
dead_a  out  1  high while channel A is in its dead interval
dead_b  out  1  high while channel B is in its dead interval
period_start  out  1  one-cycle pulse, registered, in the cycle after the tick on which the shared counter wraps to 0

Behaviour:
- Reset (rst high at a clk edge):
  - All outputs go to 0.
  - Shared counter goes to 0.
  - Per channel: shadow and active duty go to 0, shadow and active dir go to 0, state goes to RUN.
- Reset has priority over every other input, including mid-dead-interval and mid-period.
- Shared period counter cnt (0..PERIOD-1):
  - Increments on tick and wraps PERIOD-1 → 0.
  - Holds while tick is low.
- Shadow registers:
  - On cmd_valid, the addressed channel's shadow duty and dir are written the next edge.
  - Duty values above PERIOD are clamped to PERIOD at write.
  - The last write before a boundary wins.
- Period boundary: the tick on which cnt wraps.
  - A channel in RUN loads the active duty/dir from its shadow.
  - A command never alters the current period.
  - A cmd_valid in the same cycle as the boundary tick is not seen until the following boundary.
- Per-channel FSM, states RUN and DEAD:
  - RUN → DEAD: at a boundary where the shadow dir differs from the active dir. In this case the active duty is not loaded, a per-channel dead counter is set to DEAD_TICKS, and dead_x is asserted.
  - DEAD: both in1_x and in2_x are 0. The dead counter decrements on each tick.
  - DEAD → RUN: on the tick where the dead counter reaches 1. The active duty/dir load from the current shadow, dead_x deasserts, and the channel resumes at the next boundary with the new dir. Outputs stay low until then.
  - Only direction changes enter DEAD. Duty-only changes never do.
- Output generation (registered; updates the edge after the tick that changes cnt):
  - RUN: active-dir pin = (cnt < active_duty); the other pin = 0.
  - Duty 0 gives a constant low. Duty PERIOD gives a constant high.
  - in1_x and in2_x are never simultaneously 1, in any state or cycle.
- en low:
  - All four bridge outputs go to 0 the next edge.
  - cnt is held at 0, both FSMs are forced to RUN, active duties are cleared to 0, and dead_x goes to 0. Shadows are retained.
  - On en rising, the first boundary (cnt wraps after PERIOD ticks) loads the shadows. No dead interval is inserted after re-enable.
- Ticks arriving on consecutive cycles are legal. Tick and cmd_valid in the same cycle: the shadow write and the counter advance both occur.

Decomposition:
- Shared package: the RUN/DEAD state encoding, the PERIOD/DEAD_TICKS defaults, and the channel-select constants CH_A=0, CH_B=1.
- One sub-module, bridge_channel:
  - Contains the shadow registers, clamp, FSM, dead counter, and output pin logic.
  - Takes clk, rst, tick, en, boundary, cnt, plus a write strobe, duty and dir.
- The top level holds the shared counter and command decode, and instantiates bridge_channel twice.

Test Plan:
1. Reset with tick every cycle, then en=1 → all outputs 0. Write A duty 20 dir 0 → after the first boundary, in1_a high exactly 20 of every 100 ticks; in2_a=0; B outputs 0.
2. Write A duty 0, then 100, then 150 in successive periods → in1_a is constant low, then constant high, then constant high (150 clamped to 100); in2_a always 0.
3. Write A duty 30 at cnt=50 with duty 60 active → the current period stays 60-high; the next period is 30-high. Write at the boundary cycle → applied one period later.
4. A running duty 40 dir 0; write dir 1 duty 40 → at the boundary dead_a=1 and both pins 0 for 4 ticks, then low until the next boundary, then in2_a high 40 ticks. in1_a & in2_a is never 1.
5. Tick every 3rd cycle → the period spans 300 clk cycles and duty 20 gives 60 cycles high. period_start pulses once per 300 cycles.
6. Drop en mid-dead-interval and assert rst mid-period → outputs 0 the next edge, dead_a=0. After reset the shadows read 0, so no drive occurs even after en=1.

Source files
------------

// File: rtl/motor_bridge_driver_pkg.sv
// Shared types and defaults for the two-channel H-bridge drive stage.
package motor_bridge_driver_pkg;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StDead = 1'b1
    } ch_state_e;

    localparam int unsigned PERIOD_DEFAULT     = 100;
    localparam int unsigned DEAD_TICKS_DEFAULT = 4;
    localparam int unsigned DUTY_W_DEFAULT     = 8;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

endpackage

// File: rtl/motor_bridge_driver_if.sv
// Command bus feeding the bridge driver: one strobe plus channel, duty and direction.
interface motor_bridge_driver_if #(
    parameter int unsigned DUTY_W = 8
) ();

    logic              cmd_valid;
    logic              cmd_ch;
    logic [DUTY_W-1:0] cmd_duty;
    logic              cmd_dir;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_duty,
        output cmd_dir
    );

    modport slave (
        input cmd_valid,
        input cmd_ch,
        input cmd_duty,
        input cmd_dir
    );

endinterface

// File: rtl/motor_bridge_driver_bridge_channel.sv
// One bridge channel: shadow/active duty and direction, reversal dead interval,
// and registered PWM pin generation against the shared period counter.
module motor_bridge_driver_bridge_channel
    import motor_bridge_driver_pkg::*;
#(
    parameter int unsigned PERIOD     = PERIOD_DEFAULT,
    parameter int unsigned DEAD_TICKS = DEAD_TICKS_DEFAULT,
    parameter int unsigned DUTY_W     = DUTY_W_DEFAULT,
    parameter int unsigned CNT_W      = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_i,
    input  logic              en_i,
    input  logic              boundary_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic              wr_i,
    input  logic [DUTY_W-1:0] wr_duty_i,
    input  logic              wr_dir_i,
    output logic              in1_o,
    output logic              in2_o,
    output logic              dead_o
);

    localparam int unsigned DEAD_W = $clog2(DEAD_TICKS + 1);

    ch_state_e         state_q, state_d;
    logic [DUTY_W-1:0] shadow_duty_q, shadow_duty_d;
    logic [DUTY_W-1:0] active_duty_q, active_duty_d;
    logic              shadow_dir_q, shadow_dir_d;
    logic              active_dir_q, active_dir_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic              park_q, park_d;
    logic              in1_q, in1_d;
    logic              in2_q, in2_d;
    logic              dead_q, dead_d;
    logic [DUTY_W-1:0] wr_duty_clamped;

    assign wr_duty_clamped = (wr_duty_i > DUTY_W'(PERIOD)) ? DUTY_W'(PERIOD) : wr_duty_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            shadow_duty_q <= '0;
            active_duty_q <= '0;
            shadow_dir_q  <= 1'b0;
            active_dir_q  <= 1'b0;
            dead_cnt_q    <= '0;
            park_q        <= 1'b0;
            in1_q         <= 1'b0;
            in2_q         <= 1'b0;
            dead_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_duty_q <= shadow_duty_d;
            active_duty_q <= active_duty_d;
            shadow_dir_q  <= shadow_dir_d;
            active_dir_q  <= active_dir_d;
            dead_cnt_q    <= dead_cnt_d;
            park_q        <= park_d;
            in1_q         <= in1_d;
            in2_q         <= in2_d;
            dead_q        <= dead_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shadow_duty_d = shadow_duty_q;
        shadow_dir_d  = shadow_dir_q;
        active_duty_d = active_duty_q;
        active_dir_d  = active_dir_q;
        dead_cnt_d    = dead_cnt_q;
        park_d        = park_q;

        if (wr_i) begin
            shadow_duty_d = wr_duty_clamped;
            shadow_dir_d  = wr_dir_i;
        end

        if (!en_i) begin
            // Tracking the shadow dir while disabled keeps re-enable free of a dead interval.
            state_d       = StRun;
            active_duty_d = '0;
            active_dir_d  = shadow_dir_d;
            dead_cnt_d    = '0;
            park_d        = 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (boundary_i) begin
                        park_d = 1'b0;
                        if (shadow_dir_q != active_dir_q) begin
                            state_d    = StDead;
                            dead_cnt_d = DEAD_W'(DEAD_TICKS);
                        end else begin
                            active_duty_d = shadow_duty_q;
                            active_dir_d  = shadow_dir_q;
                        end
                    end
                end
                StDead: begin
                    if (tick_i) begin
                        if (dead_cnt_q == DEAD_W'(1)) begin
                            // Park until the next boundary so the new dir starts period-aligned.
                            state_d       = StRun;
                            active_duty_d = shadow_duty_q;
                            active_dir_d  = shadow_dir_q;
                            dead_cnt_d    = '0;
                            park_d        = 1'b1;
                        end else begin
                            dead_cnt_d = dead_cnt_q - DEAD_W'(1);
                        end
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        in1_d  = 1'b0;
        in2_d  = 1'b0;
        dead_d = en_i && (state_q == StDead);
        if (en_i && (state_q == StRun) && !park_q && (DUTY_W'(cnt_i) < active_duty_q)) begin
            if (active_dir_q) begin
                in2_d = 1'b1;
            end else begin
                in1_d = 1'b1;
            end
        end
    end

    assign in1_o  = in1_q;
    assign in2_o  = in2_q;
    assign dead_o = dead_q;

endmodule

// File: rtl/motor_bridge_driver.sv
// Two-channel H-bridge drive stage: shared tick-driven period counter, command
// decode, and one bridge channel per motor.
module motor_bridge_driver
    import motor_bridge_driver_pkg::*;
#(
    parameter int unsigned PERIOD     = PERIOD_DEFAULT,
    parameter int unsigned DEAD_TICKS = DEAD_TICKS_DEFAULT,
    parameter int unsigned DUTY_W     = DUTY_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 en,
    motor_bridge_driver_if.slave bus,
    output logic                 in1_a,
    output logic                 in2_a,
    output logic                 in1_b,
    output logic                 in2_b,
    output logic                 dead_a,
    output logic                 dead_b,
    output logic                 period_start
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             period_start_q, period_start_d;
    logic             wrap;
    logic             boundary;
    logic             wr_a;
    logic             wr_b;

    assign wrap     = (cnt_q == CNT_W'(PERIOD - 1));
    assign boundary = en && tick && wrap;
    assign wr_a     = bus.cmd_valid && (bus.cmd_ch == CH_A);
    assign wr_b     = bus.cmd_valid && (bus.cmd_ch == CH_B);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
        end
    end

    always_comb begin
        cnt_d          = cnt_q;
        period_start_d = boundary;
        if (!en) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign period_start = period_start_q;

    motor_bridge_driver_bridge_channel #(
        .PERIOD     (PERIOD),
        .DEAD_TICKS (DEAD_TICKS),
        .DUTY_W     (DUTY_W),
        .CNT_W      (CNT_W)
    ) u_ch_a (
        .clk        (clk),
        .rst        (rst),
        .tick_i     (tick),
        .en_i       (en),
        .boundary_i (boundary),
        .cnt_i      (cnt_q),
        .wr_i       (wr_a),
        .wr_duty_i  (bus.cmd_duty),
        .wr_dir_i   (bus.cmd_dir),
        .in1_o      (in1_a),
        .in2_o      (in2_a),
        .dead_o     (dead_a)
    );

    motor_bridge_driver_bridge_channel #(
        .PERIOD     (PERIOD),
        .DEAD_TICKS (DEAD_TICKS),
        .DUTY_W     (DUTY_W),
        .CNT_W      (CNT_W)
    ) u_ch_b (
        .clk        (clk),
        .rst        (rst),
        .tick_i     (tick),
        .en_i       (en),
        .boundary_i (boundary),
        .cnt_i      (cnt_q),
        .wr_i       (wr_b),
        .wr_duty_i  (bus.cmd_duty),
        .wr_dir_i   (bus.cmd_dir),
        .in1_o      (in1_b),
        .in2_o      (in2_b),
        .dead_o     (dead_b)
    );

endmodule

// File: tb/tb_motor_bridge_driver.sv
// Directed bench for motor_bridge_driver: per-period high-time counts, dead
// interval, clamp, command timing, enable drop and mid-period reset.
module tb_motor_bridge_driver;
    import motor_bridge_driver_pkg::*;

    logic clk;
    logic rst;
    logic tick;
    logic en;
    logic in1_a, in2_a, in1_b, in2_b, dead_a, dead_b, period_start;

    int errors   = 0;
    int checks   = 0;
    int tick_div = 1;
    int tick_ph  = 0;
    int overlap  = 0;
    int m_a1, m_a2, m_b1, m_b2, m_da, m_db, m_ps;
    int waited;

    motor_bridge_driver_if #(.DUTY_W(8)) bus ();

    motor_bridge_driver #(
        .PERIOD     (100),
        .DEAD_TICKS (4),
        .DUTY_W     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .en           (en),
        .bus          (bus),
        .in1_a        (in1_a),
        .in2_a        (in2_a),
        .in1_b        (in1_b),
        .in2_b        (in2_b),
        .dead_a       (dead_a),
        .dead_b       (dead_b),
        .period_start (period_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick strobe every tick_div cycles, driven away from the active edge.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_ph++;
            tick = ((tick_ph % tick_div) == 0);
        end
    end

    always @(negedge clk) begin
        if ((in1_a && in2_a) || (in1_b && in2_b)) overlap++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] outs();
        return {period_start, dead_b, dead_a, in2_b, in1_b, in2_a, in1_a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic ch, input logic [7:0] duty, input logic dir);
        bus.cmd_valid = 1'b1;
        bus.cmd_ch    = ch;
        bus.cmd_duty  = duty;
        bus.cmd_dir   = dir;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_ps(output int n);
        n = 0;
        while (period_start !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("ps_seen", {31'd0, period_start}, 1);
    endtask

    // Samples n cycles after a period_start; optional write issued after sample wr_at.
    task automatic measure(input int n, input int wr_at, input logic ch,
                           input logic [7:0] duty, input logic dir);
        m_a1 = 0; m_a2 = 0; m_b1 = 0; m_b2 = 0; m_da = 0; m_db = 0; m_ps = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            m_a1 += int'(in1_a);
            m_a2 += int'(in2_a);
            m_b1 += int'(in1_b);
            m_b2 += int'(in2_b);
            m_da += int'(dead_a);
            m_db += int'(dead_b);
            m_ps += int'(period_start);
            if (k == wr_at) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_ch    = ch;
                bus.cmd_duty  = duty;
                bus.cmd_dir   = dir;
            end else begin
                bus.cmd_valid = 1'b0;
            end
        end
    endtask

    task automatic win(input string tag, input int n, input int wr_at, input logic ch,
                       input logic [7:0] duty, input logic dir,
                       input int ea1, input int ea2, input int eb1, input int eb2,
                       input int eda, input int edb);
        int w;
        wait_ps(w);
        measure(n, wr_at, ch, duty, dir);
        chk({tag, ".in1_a"}, m_a1, ea1);
        chk({tag, ".in2_a"}, m_a2, ea2);
        chk({tag, ".in1_b"}, m_b1, eb1);
        chk({tag, ".in2_b"}, m_b2, eb2);
        chk({tag, ".dead_a"}, m_da, eda);
        chk({tag, ".dead_b"}, m_db, edb);
        chk({tag, ".ps"}, m_ps, 1);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_ch    = 1'b0;
        bus.cmd_duty  = 8'd0;
        bus.cmd_dir   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {25'd0, outs()}, 0);
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);
        chk("enabled_idle_outs", {25'd0, outs()}, 0);

        send(CH_A, 8'd20, 1'b0);
        win("p20",         100, -1, CH_A, 8'd0,   1'b0, 20,  0,  0, 0, 0, 0);
        win("hold20",      100,  1, CH_A, 8'd0,   1'b0, 20,  0,  0, 0, 0, 0);
        win("duty0",       100,  1, CH_A, 8'd100, 1'b0,  0,  0,  0, 0, 0, 0);
        win("duty100",     100,  1, CH_A, 8'd150, 1'b0, 100, 0,  0, 0, 0, 0);
        win("clamp150",    100,  1, CH_A, 8'd60,  1'b0, 100, 0,  0, 0, 0, 0);
        win("mid_write",   100, 50, CH_A, 8'd30,  1'b0, 60,  0,  0, 0, 0, 0);
        win("bnd_write",   100, 99, CH_A, 8'd70,  1'b0, 30,  0,  0, 0, 0, 0);
        win("bnd_hold",    100, -1, CH_A, 8'd0,   1'b0, 30,  0,  0, 0, 0, 0);
        win("bnd_applied", 100,  1, CH_A, 8'd40,  1'b0, 70,  0,  0, 0, 0, 0);
        win("pre_rev",     100,  1, CH_A, 8'd40,  1'b1, 40,  0,  0, 0, 0, 0);
        win("dead",        100, -1, CH_A, 8'd0,   1'b0,  0,  0,  0, 0, 4, 0);
        win("rev",         100,  1, CH_B, 8'd10,  1'b0,  0, 40,  0, 0, 0, 0);
        win("b_run",       100, -1, CH_A, 8'd0,   1'b0,  0, 40, 10, 0, 0, 0);

        tick_div = 3;
        wait_ps(waited);
        measure(300, -1, CH_A, 8'd0, 1'b0);
        win("tick3",       300, -1, CH_A, 8'd0,   1'b0,  0, 120, 30, 0, 0, 0);

        tick_div = 1;
        send(CH_A, 8'd40, 1'b0);
        wait_ps(waited);
        repeat (2) @(negedge clk);
        chk("dead_a_entered", {31'd0, dead_a}, 1);
        chk("dead_pins_low", {30'd0, in1_a, in2_a}, 0);
        en = 1'b0;
        @(negedge clk);
        chk("en_drop_outs", {25'd0, outs()}, 0);
        repeat (3) @(negedge clk);
        en = 1'b1;
        win("reenable",    100, -1, CH_A, 8'd0,   1'b0, 40,  0, 10, 0, 0, 0);

        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", {25'd0, outs()}, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_ps(waited);
        chk("rst_cnt_restart", waited, 100);
        win("post_rst",    100, -1, CH_A, 8'd0,   1'b0,  0,  0,  0, 0, 0, 0);

        chk("no_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
